intersection_scheduler: RTL

//  Sequences the signal heads of a two-road intersection: main road (NS) and side road (EW).

---
 rtl/intersection_scheduler_pkg.sv | 51 +++++
 rtl/intersection_scheduler_chk.sv | 28 ++
 rtl/intersection_scheduler_phase_timer.sv | 40 ++++
 rtl/intersection_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/intersection_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// intersection_scheduler_pkg
// Shared definitions for the two-road intersection scheduler:
//   - phase_e     : state codes 0..6 (also exported on the debug phase port)
//   - LAMP_*      : {red, yellow, green} lamp encodings for one signal head
//   - lamps_t     : both heads plus the pedestrian walk lamp
//   - decode_lamps: maps a phase to the lamp pattern it shows
// -----------------------------------------------------------------------------
package intersection_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_NS_G = 3'd0,
        ST_NS_Y = 3'd1,
        ST_AR1  = 3'd2,
        ST_EW_G = 3'd3,
        ST_EW_Y = 3'd4,
        ST_AR2  = 3'd5,
        ST_PED  = 3'd6
    } phase_e;

    // Head encoding is {red, yellow, green}, one-hot.
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamps_t;

    // Anything unrecognised shows all-red: the safe fallback.
    function automatic lamps_t decode_lamps(input phase_e ph);
        lamps_t l;
        l.ns   = LAMP_R;
        l.ew   = LAMP_R;
        l.walk = 1'b0;
        case (ph)
            ST_NS_G: l.ns = LAMP_G;
            ST_NS_Y: l.ns = LAMP_Y;
            ST_AR1:  l.ns = LAMP_R;
            ST_EW_G: l.ew = LAMP_G;
            ST_EW_Y: l.ew = LAMP_Y;
            ST_AR2:  l.ew = LAMP_R;
            ST_PED:  l.walk = 1'b1;
            default: l.walk = 1'b0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_scheduler_chk.sv
// -----------------------------------------------------------------------------
// intersection_scheduler_chk
// Safety checker for the intersection lamps: never two conflicting approaches
// non-red, walk only with both heads red, and each head strictly one-hot.
// Ports: clk, reset (active-low) and the seven lamp outputs of the scheduler.
// -----------------------------------------------------------------------------
module intersection_scheduler_chk (
    input logic clk,
    input logic reset,
    input logic ns_r,
    input logic ns_y,
    input logic ns_g,
    input logic ew_r,
    input logic ew_y,
    input logic ew_g,
    input logic walk
);

    a_no_conflict: assert property (@(posedge clk) disable iff (!reset)
        !((ns_g || ns_y) && (ew_g || ew_y)));

    a_walk_all_red: assert property (@(posedge clk) disable iff (!reset)
        walk |-> (ns_r && ew_r));

    a_onehot_heads: assert property (@(posedge clk) disable iff (!reset)
        $onehot({ns_r, ns_y, ns_g}) && $onehot({ew_r, ew_y, ew_g}));

endmodule

// File: rtl/intersection_scheduler_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Dwell counter for the intersection FSM. Clears when the FSM changes state,
// otherwise counts up and saturates at all-ones so a long-held phase never
// wraps back into a "just entered" count.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_clear  in   clear to zero on this edge (state change)
//   o_count  out  CNT_W-bit current count
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    // Clear / saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (!(&r_count)) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
// Sequences the NS (main) and EW (side) signal heads of a two-road
// intersection. NS green is the default; EW vehicle requests and pedestrian
// requests are latched and served after the NS minimum green, always through
// yellow and an all-red clearance.
//
// Optional feature macro: PED_WALK_EN
//   defined   : a pedestrian request inserts an all-red PED phase with walk=1
//   undefined : a pedestrian request is treated as an EW request, walk=0
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   ew_sensor  in   EW vehicle present (level or pulse)
//   ped_btn    in   pedestrian request (pulse)
//   ns_r/y/g   out  NS head, one-hot, registered
//   ew_r/y/g   out  EW head, one-hot, registered
//   walk       out  pedestrian walk lamp, registered
//   phase      out  current state code (debug)
// -----------------------------------------------------------------------------
module intersection_scheduler
    import intersection_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned NS_MIN  = 8,
    parameter int unsigned EW_GRN  = 6,
    parameter int unsigned YEL     = 3,
    parameter int unsigned ALL_RED = 1,
    parameter int unsigned WALK    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ew_sensor,
    input  logic       ped_btn,
    output logic       ns_r,
    output logic       ns_y,
    output logic       ns_g,
    output logic       ew_r,
    output logic       ew_y,
    output logic       ew_g,
    output logic       walk,
    output logic [2:0] phase
);

    // A dwell of D cycles ends when the timer reads D-1.
    localparam logic [CNT_W-1:0] NS_MIN_M1  = CNT_W'(NS_MIN - 1);
    localparam logic [CNT_W-1:0] EW_GRN_M1  = CNT_W'(EW_GRN - 1);
    localparam logic [CNT_W-1:0] YEL_M1     = CNT_W'(YEL - 1);
    localparam logic [CNT_W-1:0] ALL_RED_M1 = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] WALK_M1    = CNT_W'(WALK - 1);

`ifdef PED_WALK_EN
    localparam logic PED_EN = 1'b1;
`else
    localparam logic PED_EN = 1'b0;
`endif

    phase_e           r_state;
    phase_e           w_next_state;
    logic [CNT_W-1:0] w_timer;
    logic             w_state_change;
    logic             w_enter_ew_g;
    logic             w_clr_ped;
    logic             w_req;
    logic             w_ew_pend_nxt;
    logic             w_ped_pend_nxt;
    lamps_t           w_lamps;

    logic             r_ew_pend;
    logic             r_ped_pend;
    logic [2:0]       r_ns;
    logic [2:0]       r_ew;
    logic             r_walk;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .i_clear (w_state_change),
        .o_count (w_timer)
    );

    // Either latched request (vehicle or pedestrian) ends the NS green.
    assign w_req = r_ew_pend | r_ped_pend;

    // Next-state selection from the current phase, dwell timer and latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_NS_G: begin
                if ((w_timer >= NS_MIN_M1) && w_req) begin
                    w_next_state = ST_NS_Y;
                end else begin
                    w_next_state = ST_NS_G;
                end
            end
            ST_NS_Y: begin
                if (w_timer == YEL_M1) begin
                    w_next_state = ST_AR1;
                end else begin
                    w_next_state = ST_NS_Y;
                end
            end
            ST_AR1: begin
                if (w_timer == ALL_RED_M1) begin
                    w_next_state = (PED_EN && r_ped_pend) ? ST_PED : ST_EW_G;
                end else begin
                    w_next_state = ST_AR1;
                end
            end
            ST_EW_G: begin
                if (w_timer == EW_GRN_M1) begin
                    w_next_state = ST_EW_Y;
                end else begin
                    w_next_state = ST_EW_G;
                end
            end
            ST_EW_Y: begin
                if (w_timer == YEL_M1) begin
                    w_next_state = ST_AR2;
                end else begin
                    w_next_state = ST_EW_Y;
                end
            end
            ST_AR2: begin
                if (w_timer == ALL_RED_M1) begin
                    w_next_state = ST_NS_G;
                end else begin
                    w_next_state = ST_AR2;
                end
            end
            ST_PED: begin
                // PED is already all-red, so NS_G can follow with no clearance.
                if (w_timer == WALK_M1) begin
                    w_next_state = r_ew_pend ? ST_EW_G : ST_NS_G;
                end else begin
                    w_next_state = ST_PED;
                end
            end
            default: begin
                w_next_state = ST_NS_G;
            end
        endcase
    end

    assign w_state_change = (w_next_state != r_state);
    assign w_enter_ew_g   = (w_next_state == ST_EW_G) && (r_state != ST_EW_G);

`ifdef PED_WALK_EN
    assign w_clr_ped = (w_next_state == ST_PED) && (r_state != ST_PED);
`else
    // Without a walk phase the EW green is what serves the pedestrian.
    assign w_clr_ped = w_enter_ew_g;
`endif

    // Clear beats a same-cycle set: the green being entered serves that request.
    assign w_ew_pend_nxt  = w_enter_ew_g ? 1'b0 : (r_ew_pend | ew_sensor);
    assign w_ped_pend_nxt = w_clr_ped    ? 1'b0 : (r_ped_pend | ped_btn);

    // Lamps are decoded from the next state so they switch with the state.
    always_comb begin
        w_lamps = decode_lamps(w_next_state);
    end

    // State, request latches and registered lamp outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_NS_G;
            r_ew_pend  <= 1'b0;
            r_ped_pend <= 1'b0;
            r_ns       <= LAMP_G;
            r_ew       <= LAMP_R;
            r_walk     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ew_pend  <= w_ew_pend_nxt;
            r_ped_pend <= w_ped_pend_nxt;
            r_ns       <= w_lamps.ns;
            r_ew       <= w_lamps.ew;
            r_walk     <= w_lamps.walk & PED_EN;
        end
    end

    assign ns_r  = r_ns[2];
    assign ns_y  = r_ns[1];
    assign ns_g  = r_ns[0];
    assign ew_r  = r_ew[2];
    assign ew_y  = r_ew[1];
    assign ew_g  = r_ew[0];
    assign walk  = r_walk;
    assign phase = r_state;

endmodule
